mac_4bit_seq: RTL
=================

# mac_4bit_seq

Job sequencer for one `MAC_4BIT` math-unit slice.
- Accepts a dot-product job descriptor and streams operand/coefficient pairs into the MAC, one per accepted beat.
- Drives the clear/round/clock-enable controls and holds the MAC configuration for the whole job.
- Captures the selected, optionally saturated 4-bit `MAC_OUT` into a result register with a valid/ready handshake.
- Sits between eFPGA fabric request logic and the MAC slice, in the same `MAC_ACC_CLK` domain.

## Interface
Parameters:
- `NTAP_W`, 4: width of `cfg_ntaps_m1`; a job has 1..2^NTAP_W taps.

Ports:
- `MAC_ACC_CLK` in 1: clock, shared with the MAC slice.
- `acc_ff_rst` in 1: reset, synchronous, active-high.
- Job request inputs (all `in`):
  - `start` 1: job request, sampled only in IDLE.
  - `abort` 1: cancel the current job.
  - `cfg_ntaps_m1` NTAP_W: tap count minus 1.
  - `cfg_out_sel` 6: output bit select, legal 0..16.
  - `cfg_tc` 1: signed (two's complement) mode.
  - `cfg_sat` 1: saturate the result.
  - `cfg_rnd` 1: round the result.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: one-cycle pulse when a start is rejected.
- Operand stream:
  - `in_valid` in 1.
  - `in_ready` out 1.
  - `in_oper` in 4.
  - `in_coef` in 4.
- Result stream:
  - `res_valid` out 1.
  - `res_ready` in 1.
  - `res_data` out 4.
- MAC drive (all `out`):
  - `EFPGA_MATHB_CLK_EN` 1.
  - `MAC_ACC_CLEAR` 1.
  - `MAC_ACC_RND` 1.
  - `MAC_ACC_SAT` 1.
  - `MAC_TC` 1.
  - `MAC_OUT_SEL` 6.
  - `MAC_OPER_DATA` 4.
  - `MAC_COEF_DATA` 4.
- `MAC_OUT` in 4: MAC result.

## Operation
States: IDLE, RUN, DRAIN, DONE.

IDLE
- `in_ready`=0 and `res_valid`=0.
- On `start` with `cfg_out_sel`<=16:
  - Latch all `cfg_*` into configuration registers.
  - Load the tap counter with `cfg_ntaps_m1`.
  - Go to RUN.
- On `start` with `cfg_out_sel`>16: pulse `err`, stay in IDLE, leave the configuration registers unchanged.

RUN
- `in_ready`=1.
- A beat is a cycle with `in_valid && in_ready`.
- `MAC_OPER_DATA`/`MAC_COEF_DATA` pass `in_oper`/`in_coef` through combinationally.
- `EFPGA_MATHB_CLK_EN` = beat.
- First beat of a job:
  - `cfg_rnd`=0: `MAC_ACC_CLEAR`=1, `MAC_ACC_RND`=0.
  - `cfg_rnd`=1: `MAC_ACC_CLEAR`=0, `MAC_ACC_RND`=1. The MAC gives CLEAR priority, so both are never high together.
- Later beats: CLEAR=0, RND=0.
- Each beat decrements the tap counter. The beat that consumes the count-0 tap moves to DRAIN.

DRAIN (exactly 1 cycle)
- `in_ready`=0, `EFPGA_MATHB_CLK_EN`=0.
- Register `MAC_OUT` into `res_data`. Go to DONE.

DONE
- `res_valid`=1. `res_data` is stable.
- `start` is ignored.
- On `res_ready`, go to IDLE.

Configuration drive
- `MAC_TC`, `MAC_ACC_SAT`, `MAC_OUT_SEL` are driven from the configuration registers in every state.
- They change only on an accepted start.

abort
- Has priority over every transition.
- In any state it forces IDLE next cycle and clears `res_valid`.
- A beat in the same cycle is neither accepted nor applied: `in_ready`=0 and CLK_EN=0 that cycle.
- The MAC accumulator is not reset. The next job's first-beat CLEAR/RND discards its contents.
- `abort` together with `start` in IDLE: `start` is ignored.

Reset
- All state and configuration registers go to 0; the state goes to IDLE.
- Every output is 0 until the first post-reset clock edge, including `MAC_OUT_SEL`=0.

## Timing
- Start accepted at cycle S: first beat accepted at S+1 at the earliest.
- Last beat accepted at cycle T: DRAIN at T+1, `res_valid` high at T+2.
- Single-tap job with `in_valid` held high: S → `res_valid` at S+3.
- `in_valid` gaps in RUN hold the accumulator (CLK_EN=0) and add cycles 1:1.
- `MAC_OUT_SEL` is stable for at least one cycle before DRAIN. This covers the MAC's internal one-cycle select delay.
- A new start may be accepted the cycle after the DONE→IDLE transition.

## Configuration
Macro `MAC_4BIT_SEQ_RND_EN`:
- Defined:
  - `cfg_rnd` is latched.
  - The first beat uses RND instead of CLEAR when `cfg_rnd`=1.
  - The MAC pre-loads its rounding constant, half an LSB at `MAC_OUT_SEL`.
- Undefined:
  - `cfg_rnd` is ignored and `MAC_ACC_RND` is tied to 0.
  - The first beat always uses CLEAR.
  - The configuration register for `cfg_rnd` is not built.

## Test plan
- Unsigned, 3 taps (3,5),(2,4),(1,1); accumulator total 24:
  - `out_sel`=0, `sat`=0 → `res_data`=0x8.
  - `out_sel`=1 → 0xC.
  - `out_sel`=0, `sat`=1 → 0xF.
- Signed (`tc`=1), `sat`=1, `out_sel`=0:
  - 1 tap (0xE,0x3) → 0xA.
  - 2 taps (0xE,0x3),(0xC,0x3), total −18 → 0x8.
- Macro defined, `rnd`=1, `out_sel`=2, 1 tap (3,2) → 0x2. Same job with `rnd`=0 → 0x1.
- 3-tap job from the first test with `in_valid` gaps of 0/2/5 cycles → same 0x8. CLK_EN high exactly 3 cycles. `res_valid` 2 cycles after the last beat.
- Abort after 2 beats, then a new 1-tap job (1,7) → 0x7, with no residue from the aborted job. `abort`+`start` in the same IDLE cycle → stays IDLE.
- `res_ready` held low 5 cycles → `res_valid`/`res_data` held and `start` ignored. Start with `cfg_out_sel`=17 → one-cycle `err`, `busy` stays 0. Reset asserted mid-RUN → all outputs 0 the next cycle.

Source files
------------

// File: rtl/mac_4bit_seq.sv
// mac_4bit_seq: job sequencer for one MAC_4BIT math-unit slice.
// Takes a dot-product job descriptor, streams operand/coefficient beats into
// the MAC, drives its clear/round/clock-enable controls, holds its
// configuration for the job and captures the 4-bit MAC result behind a
// valid/ready handshake.
// Optional feature macro: MAC_4BIT_SEQ_RND_EN (enables the first-beat round
// pre-load instead of a clear when cfg_rnd is set).
module mac_4bit_seq #(
    parameter int NTAP_W = 4
) (
    input  logic              MAC_ACC_CLK,
    input  logic              acc_ff_rst,
    // job request
    input  logic              start,
    input  logic              abort,
    input  logic [NTAP_W-1:0] cfg_ntaps_m1,
    input  logic [5:0]        cfg_out_sel,
    input  logic              cfg_tc,
    input  logic              cfg_sat,
    input  logic              cfg_rnd,
    output logic              busy,
    output logic              err,
    // operand stream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_oper,
    input  logic [3:0]        in_coef,
    // result stream
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_data,
    // MAC drive
    output logic              EFPGA_MATHB_CLK_EN,
    output logic              MAC_ACC_CLEAR,
    output logic              MAC_ACC_RND,
    output logic              MAC_ACC_SAT,
    output logic              MAC_TC,
    output logic [5:0]        MAC_OUT_SEL,
    output logic [3:0]        MAC_OPER_DATA,
    output logic [3:0]        MAC_COEF_DATA,
    input  logic [3:0]        MAC_OUT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] MAX_SEL = 6'd16;

    state_t            r_state;
    logic [NTAP_W-1:0] r_cnt;
    logic              r_first;
    logic              r_cfg_tc;
    logic              r_cfg_sat;
    logic [5:0]        r_cfg_sel;
    logic [3:0]        r_res_data;
    logic              r_err;

    state_t            w_next;
    logic              w_in_ready;
    logic              w_beat;
    logic              w_accept;
    logic              w_reject;
    logic              w_clear;
    logic              w_rnd;

`ifdef MAC_4BIT_SEQ_RND_EN
    logic              r_cfg_rnd;
`else
    // Rounding is not built in this configuration; the request bit is dropped.
    logic              w_unused_rnd;
    assign w_unused_rnd = cfg_rnd;
`endif

    // State register; abort and reset both land in IDLE.
    always_ff @(posedge MAC_ACC_CLK) begin
        if (acc_ff_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, beat qualification and first-beat clear/round selection.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_beat     = 1'b0;
        w_accept   = 1'b0;
        w_reject   = 1'b0;
        w_clear    = 1'b0;
        w_rnd      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // abort in the same cycle suppresses the start entirely
                if (start && !abort) begin
                    if (cfg_out_sel <= MAX_SEL) begin
                        w_accept = 1'b1;
                        w_next   = S_RUN;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // an aborting cycle neither offers nor applies a beat
                w_in_ready = !abort;
                w_beat     = in_valid && w_in_ready;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_beat && (r_cnt == '0)) begin
                    w_next = S_DRAIN;
                end
                if (w_beat && r_first) begin
`ifdef MAC_4BIT_SEQ_RND_EN
                    // the MAC gives CLEAR priority, so never raise both
                    if (r_cfg_rnd) begin
                        w_rnd = 1'b1;
                    end else begin
                        w_clear = 1'b1;
                    end
`else
                    w_clear = 1'b1;
`endif
                end
            end
            S_DRAIN: begin
                w_next = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (abort || res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Job configuration, tap counter, first-beat flag, result and error pulse.
    always_ff @(posedge MAC_ACC_CLK) begin
        if (acc_ff_rst) begin
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_cfg_tc   <= 1'b0;
            r_cfg_sat  <= 1'b0;
            r_cfg_sel  <= '0;
            r_res_data <= '0;
            r_err      <= 1'b0;
`ifdef MAC_4BIT_SEQ_RND_EN
            r_cfg_rnd  <= 1'b0;
`endif
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_cnt     <= cfg_ntaps_m1;
                r_first   <= 1'b1;
                r_cfg_tc  <= cfg_tc;
                r_cfg_sat <= cfg_sat;
                r_cfg_sel <= cfg_out_sel;
`ifdef MAC_4BIT_SEQ_RND_EN
                r_cfg_rnd <= cfg_rnd;
`endif
            end else if (w_beat) begin
                r_cnt   <= r_cnt - 1'b1;
                r_first <= 1'b0;
            end
            // MAC_OUT has settled on the final accumulator by DRAIN
            if ((r_state == S_DRAIN) && !abort) begin
                r_res_data <= MAC_OUT;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;
    assign in_ready  = w_in_ready;
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res_data;

    assign EFPGA_MATHB_CLK_EN = w_beat;
    assign MAC_ACC_CLEAR      = w_clear;
    assign MAC_ACC_RND        = w_rnd;
    assign MAC_ACC_SAT        = r_cfg_sat;
    assign MAC_TC             = r_cfg_tc;
    assign MAC_OUT_SEL        = r_cfg_sel;
    // operands only reach the MAC while a job is running
    assign MAC_OPER_DATA      = (r_state == S_RUN) ? in_oper : 4'd0;
    assign MAC_COEF_DATA      = (r_state == S_RUN) ? in_coef : 4'd0;

endmodule
